// File: rtl/ariane_regfile_clr.sv
// Multi-port register file with a sequential clear sweep.
// Reads are combinational; writes commit on the rising clock edge.
// A clear request walks an index over every register, zeroing one per cycle.
module ariane_regfile_clr #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NR_REGS        = 32,
  parameter int unsigned NR_READ_PORTS  = 2,
  parameter int unsigned NR_WRITE_PORTS = 2,
  parameter bit          ZERO_REG       = 1'b1,
  parameter bit          BYPASS         = 1'b0,
  localparam int unsigned ADDR_W        = $clog2(NR_REGS)
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [NR_READ_PORTS-1:0][ADDR_W-1:0]       raddr_i,
  output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]   rdata_o,
  input  logic [NR_WRITE_PORTS-1:0][ADDR_W-1:0]      waddr_i,
  input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]  wdata_i,
  input  logic [NR_WRITE_PORTS-1:0]                  we_i,
  input  logic                                       clear_req_i,
  output logic                                       clear_busy_o,
  output logic                                       clear_done_o,
  output logic                                       wr_conflict_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NR_REGS - 1);

  state_t                               state_reg, state_next;
  logic [ADDR_W-1:0]                    index_reg, index_next;
  logic                                 conflict_reg, conflict_next;
  logic [NR_REGS-1:0][DATA_WIDTH-1:0]   regs;

  // FSM state, sweep index and collision flag; reset aborts any sweep
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      index_reg    <= '0;
      conflict_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      index_reg    <= index_next;
      conflict_reg <= conflict_next;
    end
  end

  // Next-state logic; requests arriving mid-sweep are simply not looked at
  always_comb begin
    state_next   = state_reg;
    index_next   = index_reg;
    clear_busy_o = 1'b0;
    clear_done_o = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clear_req_i) begin
          state_next = CLEAR;
          index_next = '0;
        end
      end
      CLEAR: begin
        clear_busy_o = 1'b1;
        index_next   = index_reg + ADDR_W'(1);
        if (index_reg == LAST_IDX) begin
          clear_done_o = 1'b1;
          state_next   = IDLE;
          index_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        index_next = '0;
      end
    endcase
  end

  // Collision detect: two enabled ports on one writable address, only in IDLE
  always_comb begin
    conflict_next = 1'b0;
    for (int a = 0; a < NR_WRITE_PORTS; a++) begin
      for (int b = a + 1; b < NR_WRITE_PORTS; b++) begin
        if (we_i[a] && we_i[b] && (waddr_i[a] == waddr_i[b]) &&
            !(ZERO_REG && (waddr_i[a] == '0))) begin
          conflict_next = 1'b1;
        end
      end
    end
    if (state_reg == CLEAR) begin
      conflict_next = 1'b0;
    end
  end

  assign wr_conflict_o = conflict_reg;

  // One storage element per register; later ports override earlier ones
  for (genvar gi = 0; gi < NR_REGS; gi++) begin : g_reg
    logic [DATA_WIDTH-1:0] q_reg, q_next;

    // Select sweep zeroing, a port write, or hold
    always_comb begin
      q_next = q_reg;
      if (state_reg == CLEAR) begin
        if (index_reg == ADDR_W'(gi)) begin
          q_next = '0;
        end
      end else begin
        for (int p = 0; p < NR_WRITE_PORTS; p++) begin
          if (we_i[p] && (waddr_i[p] == ADDR_W'(gi))) begin
            q_next = wdata_i[p];
          end
        end
      end
      if (ZERO_REG && (gi == 0)) begin
        q_next = '0;
      end
    end

    // Register storage, cleared by reset
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        q_reg <= '0;
      end else begin
        q_reg <= q_next;
      end
    end

    assign regs[gi] = q_reg;
  end

  // Read ports: forced to zero during a sweep and for the hardwired zero register
  for (genvar gi = 0; gi < NR_READ_PORTS; gi++) begin : g_rd
    always_comb begin
      rdata_o[gi] = regs[raddr_i[gi]];
      if (BYPASS) begin
        for (int p = 0; p < NR_WRITE_PORTS; p++) begin
          if (we_i[p] && (waddr_i[p] == raddr_i[gi])) begin
            rdata_o[gi] = wdata_i[p];
          end
        end
      end
      if ((state_reg == CLEAR) || (ZERO_REG && (raddr_i[gi] == '0))) begin
        rdata_o[gi] = '0;
      end
    end
  end

endmodule

// File: tb/tb_ariane_regfile_clr.sv
// Bench for ariane_regfile_clr (default parameters: 32x32, 2R/2W, zero reg, no bypass).
// A register-array model is checked every cycle; directed steps add literal checks.
module tb_ariane_regfile_clr;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0][4:0]  raddr;
  logic [1:0][31:0] rdata;
  logic [1:0][4:0]  waddr;
  logic [1:0][31:0] wdata;
  logic [1:0]       we;
  logic             clear_req;
  logic             busy, done, conf;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // reference state
  logic [31:0] m_regs [32];
  bit          clr_active = 1'b0;
  int          clr_pos    = 0;
  bit          m_conf     = 1'b0;
  int          cnt [32];
  logic [31:0] exp_val;

  ariane_regfile_clr dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .raddr_i       (raddr),
    .rdata_o       (rdata),
    .waddr_i       (waddr),
    .wdata_i       (wdata),
    .we_i          (we),
    .clear_req_i   (clear_req),
    .clear_busy_o  (busy),
    .clear_done_o  (done),
    .wr_conflict_o (conf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Compare against the model at each falling edge, then advance the model
  // with the inputs that the coming rising edge will sample.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int r = 0; r < 2; r++) begin
        exp_val = (clr_active || raddr[r] == 5'd0) ? 32'd0 : m_regs[raddr[r]];
        chk($sformatf("model_rdata%0d", r), rdata[r], exp_val);
      end
      chk("model_busy", {31'd0, busy}, {31'd0, clr_active});
      chk("model_done", {31'd0, done}, {31'd0, clr_active && clr_pos == 31});
      chk("model_conflict", {31'd0, conf}, {31'd0, m_conf});

      if (rst) begin
        for (int a = 0; a < 32; a++) m_regs[a] = 32'd0;
        clr_active = 1'b0;
        clr_pos    = 0;
        m_conf     = 1'b0;
      end else if (clr_active) begin
        m_conf          = 1'b0;
        m_regs[clr_pos] = 32'd0;
        clr_pos++;
        if (clr_pos == 32) begin
          clr_active = 1'b0;
          clr_pos    = 0;
        end
      end else begin
        for (int a = 0; a < 32; a++) cnt[a] = 0;
        m_conf = 1'b0;
        for (int p = 0; p < 2; p++) begin
          if (we[p]) begin
            cnt[waddr[p]]++;
            if (waddr[p] != 5'd0) m_regs[waddr[p]] = wdata[p];
          end
        end
        for (int a = 1; a < 32; a++) if (cnt[a] > 1) m_conf = 1'b1;
        if (clear_req) begin
          clr_active = 1'b1;
          clr_pos    = 0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we        = 2'b00;
    clear_req = 1'b0;
    rst       = 1'b0;
  endtask

  // Request a sweep, then run up to 40 cycles tracking busy/done.
  task automatic sweep(input int req_at, input int rst_at, input bit noise, input bit wr_same,
                       output int busy_n, output int done_n, output int done_at);
    busy_n  = 0;
    done_n  = 0;
    done_at = 0;
    clear_req = 1'b1;
    we        = wr_same ? 2'b01 : 2'b00;
    waddr[0]  = 5'd2;
    wdata[0]  = 32'h0000_0055;
    cyc();
    for (int c = 1; c <= 40; c++) begin
      clear_req = (c == req_at);
      rst       = (c == rst_at);
      if (noise && c <= 32) begin
        we       = 2'b11;
        waddr[0] = 5'($urandom_range(1, 31));
        waddr[1] = (c % 2 == 1) ? waddr[0] : 5'($urandom_range(1, 31));
        wdata[0] = $urandom;
        wdata[1] = $urandom;
        raddr[0] = 5'($urandom_range(0, 31));
        raddr[1] = waddr[1];
      end else begin
        we = 2'b00;
      end
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = busy_n;
      end
      cyc();
    end
    idle_inputs();
  endtask

  task automatic fill();
    for (int a = 1; a < 32; a++) begin
      we       = 2'b01;
      waddr[0] = 5'(a);
      wdata[0] = 32'h0000_0100 + 32'(a);
      cyc();
    end
    we = 2'b00;
  endtask

  task automatic all_zero(input string name);
    for (int a = 0; a < 32; a++) begin
      raddr[0] = 5'(a);
      raddr[1] = 5'(31 - a);
      @(negedge clk);
      chk(name, rdata[0], 32'd0);
      cyc();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bn, dn, da;
    for (int a = 0; a < 32; a++) m_regs[a] = 32'd0;
    rst = 1'b1; we = 2'b00; clear_req = 1'b0;
    raddr = '0; waddr = '0; wdata = '0;
    cyc();
    chk_en = 1'b1;

    // reset state
    raddr[0] = 5'd5; raddr[1] = 5'd31;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_conflict", {31'd0, conf}, 32'd0);
    chk("reset_rdata5", rdata[0], 32'd0);
    chk("reset_rdata31", rdata[1], 32'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // single write, same-cycle read sees old value
    we = 2'b01; waddr[0] = 5'd5; wdata[0] = 32'h0000_007B; raddr[0] = 5'd5;
    @(negedge clk);
    chk("wr5_same_cycle", rdata[0], 32'd0);
    cyc();
    we = 2'b00;
    @(negedge clk);
    chk("wr5_next_cycle", rdata[0], 32'h0000_007B);
    cyc();

    // two ports on address 3: port 1 wins, flag for exactly one cycle
    we = 2'b11; waddr[0] = 5'd3; waddr[1] = 5'd3;
    wdata[0] = 32'h11; wdata[1] = 32'h22; raddr[1] = 5'd3;
    @(negedge clk);
    chk("conflict_before", {31'd0, conf}, 32'd0);
    cyc();
    we = 2'b00;
    @(negedge clk);
    chk("conflict_reg3", rdata[1], 32'h22);
    chk("conflict_flag", {31'd0, conf}, 32'd1);
    cyc();
    @(negedge clk);
    chk("conflict_clears", {31'd0, conf}, 32'd0);
    cyc();

    // both ports on zero register: dropped, no flag
    we = 2'b11; waddr[0] = 5'd0; waddr[1] = 5'd0;
    wdata[0] = 32'hDEAD_BEEF; wdata[1] = 32'hDEAD_BEEF; raddr[0] = 5'd0;
    cyc();
    we = 2'b00;
    @(negedge clk);
    chk("zero_reg_rdata", rdata[0], 32'd0);
    chk("zero_reg_conflict", {31'd0, conf}, 32'd0);
    cyc();

    // two ports on distinct addresses: both land, no flag
    we = 2'b11; waddr[0] = 5'd7; waddr[1] = 5'd9;
    wdata[0] = 32'hA5A5_0007; wdata[1] = 32'h5A5A_0009;
    raddr[0] = 5'd7; raddr[1] = 5'd9;
    cyc();
    we = 2'b00;
    @(negedge clk);
    chk("dual_wr7", rdata[0], 32'hA5A5_0007);
    chk("dual_wr9", rdata[1], 32'h5A5A_0009);
    chk("dual_conflict", {31'd0, conf}, 32'd0);
    cyc();

    // full sweep with writes dropped during it; request cycle also writes reg 2
    fill();
    raddr[0] = 5'd31;
    @(negedge clk);
    chk("fill_reg31", rdata[0], 32'h0000_011F);
    sweep(0, 0, 1'b1, 1'b1, bn, dn, da);
    chk("sweep_busy_cycles", 32'(bn), 32'd32);
    chk("sweep_done_pulses", 32'(dn), 32'd1);
    chk("sweep_done_on_last", 32'(da), 32'd32);
    all_zero("sweep_all_zero");

    // reset at sweep cycle 10 aborts without a done pulse
    fill();
    sweep(0, 10, 1'b0, 1'b0, bn, dn, da);
    chk("abort_busy_cycles", 32'(bn), 32'd10);
    chk("abort_done_pulses", 32'(dn), 32'd0);
    all_zero("abort_all_zero");

    // re-request at sweep cycle 5 neither restarts nor extends
    fill();
    sweep(5, 0, 1'b0, 1'b0, bn, dn, da);
    chk("rereq_busy_cycles", 32'(bn), 32'd32);
    chk("rereq_done_pulses", 32'(dn), 32'd1);
    chk("rereq_done_on_last", 32'(da), 32'd32);
    all_zero("rereq_all_zero");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ariane_regfile_clr.md
ARIANE_REGFILE_CLR -- requirements
Module: ariane_regfile_clr

Interface
REQ-001: Parameter DATA_WIDTH, default 32, width of each register in bits.
REQ-002: Parameter NR_REGS, default 32, register count; power of two, >= 2; ADDR_W = log2(NR_REGS).
REQ-003: Parameter NR_READ_PORTS, default 2, number of read ports, >= 1.
REQ-004: Parameter NR_WRITE_PORTS, default 2, number of write ports, >= 1.
REQ-005: Parameter ZERO_REG, default 1; when 1, register 0 reads 0 and is never written.
REQ-006: Parameter BYPASS, default 0; when 1, reads return same-cycle write data.
REQ-007: Single clock domain; reset is synchronous and active-high.
REQ-008: clk_i  input  1  clock; all state updates on rising edge.
REQ-009: rst_i  input  1  synchronous active-high reset.
REQ-010: raddr_i  input  NR_READ_PORTS x ADDR_W  read addresses.
REQ-011: rdata_o  output  NR_READ_PORTS x DATA_WIDTH  read data, combinational from raddr_i.
REQ-012: waddr_i  input  NR_WRITE_PORTS x ADDR_W  write addresses.
REQ-013: wdata_i  input  NR_WRITE_PORTS x DATA_WIDTH  write data.
REQ-014: we_i  input  NR_WRITE_PORTS  per-port write enable.
REQ-015: clear_req_i  input  1  request sequential clear of all registers.
REQ-016: clear_busy_o  output  1  high while clear sweep is in progress.
REQ-017: clear_done_o  output  1  one-cycle pulse on final clear cycle.
REQ-018: wr_conflict_o  output  1  registered flag: previous cycle had a multi-port write collision.

Function
REQ-019: Writes SHALL commit on the rising edge when we_i[p]=1; new value visible to reads the following cycle (BYPASS=0).
REQ-020: Two or more enabled ports targeting the same address SHALL resolve to the highest-indexed port.
REQ-021: wr_conflict_o SHALL be 1 in cycle N+1 iff in cycle N at least two enabled ports targeted the same writable address (ZERO_REG=1: address 0 excluded), outside CLEAR.
REQ-022: ZERO_REG=1: writes to address 0 SHALL be dropped; rdata_o for address 0 SHALL be 0 regardless of BYPASS.
REQ-023: BYPASS=1: if an enabled write port targets raddr_i[r] this cycle, rdata_o[r] SHALL equal that port's wdata_i (highest index wins); otherwise array value.
REQ-024: FSM states IDLE, CLEAR; IDLE + clear_req_i=1 -> CLEAR with index counter = 0.
REQ-025: In CLEAR, each cycle SHALL write 0 to register[index] and increment index; at index = NR_REGS-1 the clear_done_o pulse is asserted and next state is IDLE.
REQ-026: Clear sweep SHALL take exactly NR_REGS cycles; clear_busy_o high for all of them, low in IDLE.
REQ-027: In CLEAR, we_i SHALL be ignored (no array update, no conflict flag), bypass disabled, and all rdata_o SHALL read 0.
REQ-028: clear_req_i asserted during CLEAR SHALL be ignored (no restart, no extension).
REQ-029: clear_req_i with same-cycle we_i in IDLE: the write commits that cycle; the sweep starts next cycle and overwrites it.
REQ-030: Index counter SHALL be ADDR_W bits; no wrap beyond NR_REGS-1 observable.

Reset
REQ-031: rst_i=1 on a rising edge SHALL zero all registers, FSM -> IDLE, index -> 0, clear_busy_o=0, clear_done_o=0, wr_conflict_o=0.
REQ-032: Reset SHALL take priority over writes and clear; reset mid-CLEAR aborts the sweep with no clear_done_o pulse.
REQ-033: rdata_o after reset SHALL be 0 for every address.

Verification
REQ-034: Reset, write port0 addr 5 data 0x0000007B, read port0 addr 5 next cycle -> 0x0000007B; same-cycle read -> 0 (BYPASS=0) or 0x7B (BYPASS=1).
REQ-035: Same cycle port0 addr 3 = 0x11, port1 addr 3 = 0x22 -> reg3 reads 0x22, wr_conflict_o=1 one cycle later for exactly one cycle.
REQ-036: ZERO_REG=1, write addr 0 = 0xDEADBEEF -> rdata addr 0 = 0, wr_conflict_o stays 0 even with both ports on addr 0.
REQ-037: Fill regs 1..31 with nonzero, pulse clear_req_i -> clear_busy_o high exactly 32 cycles, clear_done_o on 32nd, writes during sweep dropped, all regs 0 afterward.
REQ-038: Assert rst_i at sweep cycle 10 -> next cycle IDLE, clear_busy_o=0, no clear_done_o pulse, all regs 0.
REQ-039: Re-assert clear_req_i at sweep cycle 5 -> sweep still ends after 32 total cycles, single clear_done_o pulse.
